aes_inv_cipher_ctrl: RTL



---
 rtl/aes_inv_cipher_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher: one inverse round per clock on a shared datapath.
// Optional abort input enabled by defining AES_INV_CIPHER_ABORT_EN.
module aes_inv_cipher_ctrl #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          reset,
`ifdef AES_INV_CIPHER_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [KW-1:0] rk_idx,
  input  logic [127:0]  rk_in,
  output logic          busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
  end
  if ((1 << KW) <= NR) begin : g_bad_kw
    $error("aes_inv_cipher_ctrl: KW too narrow for NR");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [127:0]    r_state_reg;
  logic [KW-1:0]   r_round_cnt;
  logic            w_abort;
  logic            w_abort_hit;
  logic [127:0]    w_shift;
  logic [127:0]    w_sub;
  logic [127:0]    w_final_out;
  logic [127:0]    w_round_out;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as x^254 by an addition chain; maps 0 to 0.
  function automatic logic [7:0] ginv(
    input logic [7:0] x
  );
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x12;
    logic [7:0] x15;
    logic [7:0] x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(x3, x3);
    x12  = gmul(x12, x12);
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] b
  );
    logic [7:0] a;
    a = {b[6:0], b[7]}
      ^ {b[4:0], b[7:5]}
      ^ {b[1:0], b[7:2]}
      ^ 8'h05;
    return ginv(a);
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

`ifdef AES_INV_CIPHER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_abort_hit = w_abort
    && (r_state == S_INIT
     || r_state == S_ROUND
     || r_state == S_FINAL);

  assign w_shift     = inv_shift_rows(r_state_reg);
  assign w_sub       = inv_sub_bytes(w_shift);
  assign w_final_out = w_sub ^ rk_in;
  assign w_round_out = inv_mix_columns(w_final_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_INIT;
      S_INIT:  w_next = S_ROUND;
      S_ROUND: if (r_round_cnt == KW'(1)) w_next = S_FINAL;
      S_FINAL: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort_hit) w_next = S_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = KW'(NR);
    unique case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_INIT:  busy = 1'b1;
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = r_round_cnt;
      end
      S_FINAL: begin
        busy   = 1'b1;
        rk_idx = '0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = r_state_reg;

  // Datapath registers; the round counter holds at 1 while moving to FINAL.
  always_ff @(posedge clk) begin
    if (reset || w_abort_hit) begin
      r_state_reg <= '0;
      r_round_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) r_state_reg <= in_data;
        end
        S_INIT: begin
          r_state_reg <= r_state_reg ^ rk_in;
          r_round_cnt <= KW'(NR - 1);
        end
        S_ROUND: begin
          r_state_reg <= w_round_out;
          if (r_round_cnt != KW'(1)) begin
            r_round_cnt <= r_round_cnt - KW'(1);
          end
        end
        S_FINAL: r_state_reg <= w_final_out;
        default: ;
      endcase
    end
  end

endmodule
